// File: rtl/wb_accel_driver.sv
// wb_accel_driver
//   Wishbone B3 classic master that runs one accelerator job: streams
//   NWORDS_IN words into the slave's input register, writes 1 to the control
//   register, polls status bit0 until done, then reads NWORDS_OUT results
//   and hands each one out on a ready/valid stream.
//
// Ports
//   clk, rst_sys              clock, synchronous active-high reset
//   start / busy / done       job request, job in progress, end-of-job pulse
//   error[1:0]                valid with done: 0 ok, 1 bus err, 2 ack timeout,
//                             3 poll limit reached
//   in_data/in_valid/in_ready input word stream
//   out_data/out_valid/out_ready result word stream
//   wbm_*                     Wishbone master port (classic cycles, sel=4'hF)
module wb_accel_driver #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter logic [31:0] IN_OFS      = 32'h0,
  parameter logic [31:0] CTRL_OFS    = 32'h4,
  parameter logic [31:0] STAT_OFS    = 32'h8,
  parameter logic [31:0] OUT_OFS     = 32'hC,
  parameter int          NWORDS_IN   = 16,
  parameter int          NWORDS_OUT  = 16,
  parameter int          ACK_TIMEOUT = 255,
  parameter int          POLL_LIMIT  = 1023
) (
  input  logic                  clk,
  input  logic                  rst_sys,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            error,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  output logic [3:0]            wbm_sel_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [2:0]            wbm_cti_o,
  output logic [1:0]            wbm_bte_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  input  logic                  wbm_rty_i,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i
);

  localparam int IN_W   = $clog2(NWORDS_IN + 1);
  localparam int OUT_W  = $clog2(NWORDS_OUT + 1);
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);
  localparam int TMR_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [IN_W-1:0]   IN_LAST   = IN_W'(NWORDS_IN);
  localparam logic [OUT_W-1:0]  OUT_LAST  = OUT_W'(NWORDS_OUT);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT);
  // Timer holds the number of cycles already spent waiting, so the access
  // is abandoned after exactly ACK_TIMEOUT cycles with cyc high.
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);

  localparam logic [ADDR_WIDTH-1:0] ADR_IN   = ADDR_WIDTH'(BASE_ADDR + IN_OFS);
  localparam logic [ADDR_WIDTH-1:0] ADR_CTRL = ADDR_WIDTH'(BASE_ADDR + CTRL_OFS);
  localparam logic [ADDR_WIDTH-1:0] ADR_STAT = ADDR_WIDTH'(BASE_ADDR + STAT_OFS);
  localparam logic [ADDR_WIDTH-1:0] ADR_OUT  = ADDR_WIDTH'(BASE_ADDR + OUT_OFS);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_IN, S_WR_CTRL, S_RD_STAT, S_RD_OUT, S_PUSH, S_FIN
  } state_t;

  state_t                state_reg,    state_next;
  logic                  cyc_reg,      cyc_next;
  logic                  we_reg,       we_next;
  logic [ADDR_WIDTH-1:0] adr_reg,      adr_next;
  logic [DATA_WIDTH-1:0] wdat_reg,     wdat_next;
  logic [DATA_WIDTH-1:0] rdat_reg,     rdat_next;
  logic [TMR_W-1:0]      tmr_reg,      tmr_next;
  logic [IN_W-1:0]       in_cnt_reg,   in_cnt_next;
  logic [OUT_W-1:0]      out_cnt_reg,  out_cnt_next;
  logic [POLL_W-1:0]     poll_cnt_reg, poll_cnt_next;
  logic [1:0]            err_reg,      err_next;
  // Set by a retried input write: the held word must be reissued before a
  // new word may be accepted.
  logic                  retry_reg,    retry_next;

  // Response decode with priority err > rty > ack.
  logic resp_err, resp_rty, resp_ack, tmr_expired;
  assign resp_err    = cyc_reg & wbm_err_i;
  assign resp_rty    = cyc_reg & wbm_rty_i & ~wbm_err_i;
  assign resp_ack    = cyc_reg & wbm_ack_i & ~wbm_err_i & ~wbm_rty_i;
  assign tmr_expired = cyc_reg & ~wbm_ack_i & ~wbm_err_i & ~wbm_rty_i & (tmr_reg == TMR_LAST);

  assign in_ready  = (state_reg == S_WR_IN) & ~cyc_reg & ~retry_reg;
  assign busy      = (state_reg != S_IDLE) & (state_reg != S_FIN);
  assign done      = (state_reg == S_FIN);
  assign error     = err_reg;
  assign out_valid = (state_reg == S_PUSH);
  assign out_data  = rdat_reg;
  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = wdat_reg;
  assign wbm_sel_o = 4'hF;
  assign wbm_cyc_o = cyc_reg;
  assign wbm_stb_o = cyc_reg;
  assign wbm_we_o  = we_reg;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;

  always_comb begin
    state_next    = state_reg;
    cyc_next      = cyc_reg;
    we_next       = we_reg;
    adr_next      = adr_reg;
    wdat_next     = wdat_reg;
    rdat_next     = rdat_reg;
    tmr_next      = '0;
    in_cnt_next   = in_cnt_reg;
    out_cnt_next  = out_cnt_reg;
    poll_cnt_next = poll_cnt_reg;
    err_next      = err_reg;
    retry_next    = retry_reg;

    if (cyc_reg) begin
      // An access is in flight: only its response or timeout moves us on.
      if (resp_err) begin
        cyc_next   = 1'b0;
        err_next   = 2'd1;
        state_next = S_FIN;
      end else if (resp_rty) begin
        // Drop for one cycle; the idle branch below reissues the same access.
        cyc_next   = 1'b0;
        retry_next = 1'b1;
      end else if (tmr_expired) begin
        cyc_next   = 1'b0;
        err_next   = 2'd2;
        state_next = S_FIN;
      end else if (resp_ack) begin
        cyc_next = 1'b0;
        case (state_reg)
          S_WR_IN: begin
            in_cnt_next = in_cnt_reg + IN_W'(1);
            if (in_cnt_reg + IN_W'(1) == IN_LAST) state_next = S_WR_CTRL;
          end
          S_WR_CTRL: state_next = S_RD_STAT;
          S_RD_STAT: begin
            if (wbm_dat_i[0]) begin
              state_next = S_RD_OUT;
            end else begin
              poll_cnt_next = poll_cnt_reg + POLL_W'(1);
              if (poll_cnt_reg + POLL_W'(1) == POLL_LAST) begin
                err_next   = 2'd3;
                state_next = S_FIN;
              end
            end
          end
          S_RD_OUT: begin
            rdat_next  = wbm_dat_i;
            state_next = S_PUSH;
          end
          default: ;
        endcase
      end else begin
        tmr_next = tmr_reg + TMR_W'(1);
      end
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_next    = S_WR_IN;
            in_cnt_next   = '0;
            out_cnt_next  = '0;
            poll_cnt_next = '0;
            err_next      = 2'd0;
            retry_next    = 1'b0;
          end
        end
        S_WR_IN: begin
          if (retry_reg) begin
            cyc_next   = 1'b1;
            retry_next = 1'b0;
          end else if (in_valid) begin
            cyc_next  = 1'b1;
            we_next   = 1'b1;
            adr_next  = ADR_IN;
            wdat_next = in_data;
          end
        end
        S_WR_CTRL: begin
          cyc_next   = 1'b1;
          retry_next = 1'b0;
          we_next    = 1'b1;
          adr_next   = ADR_CTRL;
          wdat_next  = DATA_WIDTH'(1);
        end
        S_RD_STAT: begin
          cyc_next   = 1'b1;
          retry_next = 1'b0;
          we_next    = 1'b0;
          adr_next   = ADR_STAT;
          wdat_next  = '0;
        end
        S_RD_OUT: begin
          cyc_next   = 1'b1;
          retry_next = 1'b0;
          we_next    = 1'b0;
          adr_next   = ADR_OUT;
          wdat_next  = '0;
        end
        S_PUSH: begin
          if (out_ready) begin
            out_cnt_next = out_cnt_reg + OUT_W'(1);
            state_next   = (out_cnt_reg + OUT_W'(1) == OUT_LAST) ? S_FIN : S_RD_OUT;
          end
        end
        S_FIN:   state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sys) begin
      state_reg    <= S_IDLE;
      cyc_reg      <= 1'b0;
      we_reg       <= 1'b0;
      adr_reg      <= '0;
      wdat_reg     <= '0;
      rdat_reg     <= '0;
      tmr_reg      <= '0;
      in_cnt_reg   <= '0;
      out_cnt_reg  <= '0;
      poll_cnt_reg <= '0;
      err_reg      <= 2'd0;
      retry_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cyc_reg      <= cyc_next;
      we_reg       <= we_next;
      adr_reg      <= adr_next;
      wdat_reg     <= wdat_next;
      rdat_reg     <= rdat_next;
      tmr_reg      <= tmr_next;
      in_cnt_reg   <= in_cnt_next;
      out_cnt_reg  <= out_cnt_next;
      poll_cnt_reg <= poll_cnt_next;
      err_reg      <= err_next;
      retry_reg    <= retry_next;
    end
  end

endmodule

// File: tb/tb_wb_accel_driver.sv
// Testbench for wb_accel_driver: a scripted Wishbone slave model plus
// scoreboard queues for the input words written to the slave and the
// result words expected on the output stream.
module tb_wb_accel_driver;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_IN   = BASE;
  localparam logic [31:0] A_CTRL = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;
  localparam logic [31:0] A_OUT  = BASE + 32'hC;
  localparam int NIN  = 4;
  localparam int NOUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_sys, start, busy, done;
  logic [1:0]  error;
  logic [31:0] in_data, out_data;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

  wb_accel_driver #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE),
    .IN_OFS(32'h0), .CTRL_OFS(32'h4), .STAT_OFS(32'h8), .OUT_OFS(32'hC),
    .NWORDS_IN(NIN), .NWORDS_OUT(NOUT), .ACK_TIMEOUT(8), .POLL_LIMIT(5)
  ) dut (
    .clk(clk), .rst_sys(rst_sys), .start(start), .busy(busy), .done(done),
    .error(error), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i), .wbm_dat_i(wbm_dat_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Slave behaviour knobs, set by the main sequence between jobs.
  logic        cfg_silent   = 1'b0;
  logic        cfg_err_ctrl = 1'b0;
  logic        cfg_rty_2nd  = 1'b0;
  int          cfg_stat_done_at = 3;
  logic [31:0] res_base = 32'h0;

  // Scoreboards.
  logic [31:0] exp_in_q[$];
  logic [31:0] exp_out_q[$];

  // Slave model: responds one cycle after seeing a new strobe.
  int   sl_in_seen, sl_stat_seen, sl_out_served;
  logic sl_rty_done;
  always @(posedge clk) begin
    if (rst_sys || (start && !busy)) begin
      wbm_ack_i     <= 1'b0;
      wbm_err_i     <= 1'b0;
      wbm_rty_i     <= 1'b0;
      wbm_dat_i     <= 32'h0;
      sl_in_seen    <= 0;
      sl_stat_seen  <= 0;
      sl_out_served <= 0;
      sl_rty_done   <= 1'b0;
    end else begin
      wbm_ack_i <= 1'b0;
      wbm_err_i <= 1'b0;
      wbm_rty_i <= 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i && !wbm_rty_i && !cfg_silent) begin
        if (cfg_err_ctrl && wbm_we_o && wbm_adr_o == A_CTRL) begin
          wbm_err_i <= 1'b1;
        end else if (cfg_rty_2nd && !sl_rty_done && wbm_we_o && wbm_adr_o == A_IN && sl_in_seen == 1) begin
          wbm_rty_i   <= 1'b1;
          sl_rty_done <= 1'b1;
        end else begin
          wbm_ack_i <= 1'b1;
          if (wbm_we_o && wbm_adr_o == A_IN) sl_in_seen <= sl_in_seen + 1;
          if (!wbm_we_o && wbm_adr_o == A_STAT) begin
            sl_stat_seen <= sl_stat_seen + 1;
            // Upper bits are junk; only bit0 signals done.
            wbm_dat_i <= (sl_stat_seen + 1 >= cfg_stat_done_at) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
          end else if (!wbm_we_o && wbm_adr_o == A_OUT) begin
            wbm_dat_i     <= res_base + 32'(sl_out_served);
            sl_out_served <= sl_out_served + 1;
          end else begin
            wbm_dat_i <= 32'hDEAD_BEEF;
          end
        end
      end
    end
  end

  // Bus / status monitor, sampled on the falling edge.
  int          n_in_wr, n_ctrl_wr, n_stat_rd, n_out_rd, n_rty, n_accepted;
  int          hi_run, last_hi_run, rty_lo, done_cnt;
  logic        rty_watch, done_seen;
  logic [1:0]  done_err;
  logic [31:0] rty_adr, rty_dat;
  initial begin
    hi_run = 0; last_hi_run = 0; rty_watch = 1'b0; rty_lo = 0;
    forever begin
      @(negedge clk);
      if (!rst_sys) begin
        if (wbm_cyc_o && wbm_ack_i) begin
          check_val("sel", 32'(wbm_sel_o), 32'hF);
          if (wbm_we_o && wbm_adr_o == A_IN) begin
            n_in_wr++;
            if (exp_in_q.size() == 0) check_val("in_unexpected_write", 32'(exp_in_q.size()), 1);
            else check_val("in_word", wbm_dat_o, exp_in_q.pop_front());
          end else if (wbm_we_o && wbm_adr_o == A_CTRL) begin
            n_ctrl_wr++;
            check_val("ctrl_data", wbm_dat_o, 32'h1);
          end else if (!wbm_we_o && wbm_adr_o == A_STAT) begin
            n_stat_rd++;
          end else if (!wbm_we_o && wbm_adr_o == A_OUT) begin
            n_out_rd++;
          end else begin
            check_val("access_adr", wbm_adr_o, wbm_we_o ? A_IN : A_STAT);
          end
        end
        if (wbm_cyc_o) hi_run++;
        else begin
          if (hi_run > 0) last_hi_run = hi_run;
          hi_run = 0;
        end
        if (rty_watch) begin
          if (!wbm_cyc_o) rty_lo++;
          else begin
            check_val("rty_gap", 32'(rty_lo), 1);
            check_val("rty_adr", wbm_adr_o, rty_adr);
            check_val("rty_dat", wbm_dat_o, rty_dat);
            rty_watch = 1'b0;
          end
        end
        if (wbm_cyc_o && wbm_rty_i) begin
          rty_watch = 1'b1; rty_lo = 0;
          rty_adr = wbm_adr_o; rty_dat = wbm_dat_o;
          n_rty++;
        end
        if (out_valid) check_val("push_no_bus", 32'(wbm_cyc_o), 0);
        if (done) begin
          done_seen = 1'b1;
          done_cnt++;
          done_err = error;
          check_val("busy_at_done", 32'(busy), 0);
        end
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", 32'(busy), 1);
  endtask

  task automatic drive_inputs(input int gap);
    for (int i = 0; i < NIN; i++) begin
      int wait_cyc;
      wait_cyc = 0;
      if (done_seen) break;
      repeat (gap) @(negedge clk);
      in_data  = $urandom();
      in_valid = 1'b1;
      while (!in_ready && !done_seen && wait_cyc < 3000) begin
        @(negedge clk);
        wait_cyc++;
      end
      if (in_ready) begin
        exp_in_q.push_back(in_data);
        n_accepted++;
        @(posedge clk);
        #1;
      end else if (!done_seen) begin
        check_val("in_ready_timeout", 32'(in_ready), 1);
      end
      in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic sink_outputs(input int n, input int stall);
    for (int i = 0; i < n; i++) begin
      int          wait_cyc;
      logic [31:0] first;
      wait_cyc = 0;
      @(negedge clk);
      while (!out_valid && !done_seen && wait_cyc < 5000) begin
        @(negedge clk);
        wait_cyc++;
      end
      if (!out_valid) begin
        check_val("out_valid_wait", 32'(out_valid), 1);
        break;
      end
      first = out_data;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check_val("out_hold_valid", 32'(out_valid), 1);
        check_val("out_hold_data", out_data, first);
      end
      out_ready = 1'b1;
      check_val("out_word", out_data, exp_out_q.pop_front());
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic clear_job(input logic [31:0] base);
    res_base = base;
    exp_in_q.delete();
    exp_out_q.delete();
    n_in_wr = 0; n_ctrl_wr = 0; n_stat_rd = 0; n_out_rd = 0; n_rty = 0; n_accepted = 0;
    done_seen = 1'b0; done_cnt = 0; done_err = 2'd0;
  endtask

  task automatic run_job(input string tag, input logic [31:0] base, input int gap, input int stall,
                         input int n_out, input int e_err, input int e_in, input int e_ctrl,
                         input int e_stat, input int e_acc);
    int wait_cyc;
    clear_job(base);
    for (int i = 0; i < n_out; i++) exp_out_q.push_back(base + 32'(i));
    do_start();
    fork
      drive_inputs(gap);
      sink_outputs(n_out, stall);
    join
    wait_cyc = 0;
    while (!done_seen && wait_cyc < 5000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_val({tag, "_done"}, 32'(done_seen), 1);
    repeat (3) @(negedge clk);
    check_val({tag, "_error"}, 32'(done_err), 32'(e_err));
    check_val({tag, "_done_count"}, 32'(done_cnt), 1);
    check_val({tag, "_busy_idle"}, 32'(busy), 0);
    check_val({tag, "_in_writes"}, 32'(n_in_wr), 32'(e_in));
    check_val({tag, "_ctrl_writes"}, 32'(n_ctrl_wr), 32'(e_ctrl));
    check_val({tag, "_stat_reads"}, 32'(n_stat_rd), 32'(e_stat));
    check_val({tag, "_out_reads"}, 32'(n_out_rd), 32'(n_out));
    check_val({tag, "_accepted"}, 32'(n_accepted), 32'(e_acc));
    $display("[TB] job %s: error=%0d in_wr=%0d ctrl=%0d stat=%0d out_rd=%0d accepted=%0d",
             tag, done_err, n_in_wr, n_ctrl_wr, n_stat_rd, n_out_rd, n_accepted);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc;
    rst_sys = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_error", 32'(error), 0);
    check_val("rst_in_ready", 32'(in_ready), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_cyc", 32'(wbm_cyc_o), 0);
    check_val("rst_stb", 32'(wbm_stb_o), 0);
    check_val("rst_we", 32'(wbm_we_o), 0);
    check_val("rst_adr", wbm_adr_o, 0);
    check_val("rst_dat", wbm_dat_o, 0);
    check_val("rst_sel", 32'(wbm_sel_o), 32'hF);
    check_val("rst_cti", 32'(wbm_cti_o), 0);
    check_val("rst_bte", 32'(wbm_bte_o), 0);
    rst_sys = 1'b0;

    // Nominal job: status done on the 3rd poll.
    run_job("nominal", 32'hA0, 0, 0, NOUT, 0, 4, 1, 3, 4);

    // Backpressure on both streams.
    run_job("backpressure", 32'hB0, 3, 5, NOUT, 0, 4, 1, 3, 4);

    // Retry on the second input write.
    cfg_rty_2nd = 1'b1;
    run_job("retry", 32'hC0, 0, 0, NOUT, 0, 4, 1, 3, 4);
    check_val("retry_count", 32'(n_rty), 1);
    cfg_rty_2nd = 1'b0;

    // Bus error on the control write.
    cfg_err_ctrl = 1'b1;
    run_job("err_ctrl", 32'hD0, 0, 0, 0, 1, 4, 0, 0, 4);
    cfg_err_ctrl = 1'b0;

    // No response at all: first input write times out after 8 cycles.
    cfg_silent = 1'b1;
    run_job("timeout", 32'hE0, 0, 0, 0, 2, 0, 0, 0, 1);
    check_val("timeout_cyc_cycles", 32'(last_hi_run), 8);
    cfg_silent = 1'b0;

    // Status never done: exactly POLL_LIMIT reads.
    cfg_stat_done_at = 1000;
    run_job("poll_limit", 32'hF0, 0, 0, 0, 3, 4, 1, 5, 4);
    cfg_stat_done_at = 3;

    // Reset while a result read is on the bus.
    clear_job(32'h100);
    do_start();
    drive_inputs(0);
    wait_cyc = 0;
    while (!(wbm_cyc_o && !wbm_we_o && wbm_adr_o == A_OUT) && wait_cyc < 2000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_val("reached_rd_out", wbm_adr_o, A_OUT);
    rst_sys = 1'b1;
    @(negedge clk);
    rst_sys = 1'b0;
    check_val("midrst_cyc", 32'(wbm_cyc_o), 0);
    check_val("midrst_stb", 32'(wbm_stb_o), 0);
    check_val("midrst_busy", 32'(busy), 0);
    check_val("midrst_out_valid", 32'(out_valid), 0);
    repeat (4) @(negedge clk);
    check_val("midrst_no_done", 32'(done_cnt), 0);
    $display("[TB] job reset_mid_rd_out: done_count=%0d", done_cnt);

    // Clean job after the mid-job reset.
    run_job("after_reset", 32'h200, 0, 0, NOUT, 0, 4, 1, 3, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
